// File: rtl/gpu_vga_timing_if.sv
// gpu_vga_timing_if: bundle between the raster timing stage and its user
// (pixel renderer / board top).
//
// Signals:
//   pix_en      advance enable (user -> timing)
//   pix_rgb     renderer colour {R[1:0],G[1:0],B[1:0]} (user -> timing)
//   x, y        current beam coordinates (timing -> user)
//   active      beam inside the visible area
//   line_start  x == 0
//   frame_start x == 0 and y == 0
//   vblank      y is in the vertical blanking interval
//   vga_out     registered TinyVGA PMOD byte
//
// Enable semantics: there is no valid/ready pair on this bus. pix_en is a
// pure qualifier: on a clock edge with pix_en=1 every register in the timing
// stage advances by one step, and pix_rgb is consumed as the colour for the
// coordinates presented on the previous enabled cycle. On a clock edge with
// pix_en=0 nothing changes and pix_rgb is ignored.
interface gpu_vga_timing_if;
  logic       pix_en;
  logic [5:0] pix_rgb;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       line_start;
  logic       frame_start;
  logic       vblank;
  logic [7:0] vga_out;

  // Renderer / board side.
  modport master (
    output pix_en,
    output pix_rgb,
    input  x,
    input  y,
    input  active,
    input  line_start,
    input  frame_start,
    input  vblank,
    input  vga_out
  );

  // Timing stage side.
  modport slave (
    input  pix_en,
    input  pix_rgb,
    output x,
    output y,
    output active,
    output line_start,
    output frame_start,
    output vblank,
    output vga_out
  );
endinterface

// File: rtl/gpu_vga_timing.sv
// gpu_vga_timing: 640x480@60 raster timing stage for the GPU tile.
//
// Generates horizontal/vertical beam counters, exposes the current beam
// coordinates and their decodes to the renderer, and delays sync/blanking by
// two enabled cycles so they line up with the renderer's one-cycle colour
// latency. vga_out is the final registered byte in TinyVGA PMOD order:
//   {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}
//
// Ports:
//   clk  pixel clock
//   rst  asynchronous active-high reset
//   bus  gpu_vga_timing_if.slave (pix_en, pix_rgb in; x, y, active,
//        line_start, frame_start, vblank, vga_out out)
//
// The block has no FSM; its only state is the two counters and the two
// pipeline stages.
module gpu_vga_timing #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  gpu_vga_timing_if.slave    bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_IDLE = ~SYNC_ACTIVE;

  logic [9:0] hc;
  logic [9:0] vc;

  // Stage 1: sync and visibility of the counters one enabled cycle ago.
  logic       s1_hs;
  logic       s1_vs;
  logic       s1_act;

  logic       hs_raw;
  logic       vs_raw;
  logic       act_raw;
  logic [5:0] rgb_masked;

  // ---------------------------------------------------------------------
  // Beam counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (bus.pix_en) begin
      if (hc == H_LAST) begin
        hc <= '0;
        if (vc == V_LAST) begin
          vc <= '0;
        end else begin
          vc <= vc + 10'd1;
        end
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Combinational decodes of the live counters (no added delay)
  // ---------------------------------------------------------------------
  always_comb begin
    act_raw = (hc < H_ACT) && (vc < V_ACT);
    hs_raw  = ((hc >= HS_START) && (hc < HS_END)) ? SYNC_ACTIVE : SYNC_IDLE;
    vs_raw  = ((vc >= VS_START) && (vc < VS_END)) ? SYNC_ACTIVE : SYNC_IDLE;
  end

  assign bus.x           = hc;
  assign bus.y           = vc;
  assign bus.active      = act_raw;
  assign bus.line_start  = (hc == 10'd0);
  assign bus.frame_start = (hc == 10'd0) && (vc == 10'd0);
  assign bus.vblank      = (vc >= V_ACT);

  // ---------------------------------------------------------------------
  // Stage 1: register sync and visibility
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hs  <= SYNC_IDLE;
      s1_vs  <= SYNC_IDLE;
      s1_act <= 1'b0;
    end else if (bus.pix_en) begin
      s1_hs  <= hs_raw;
      s1_vs  <= vs_raw;
      s1_act <= act_raw;
    end
  end

  // The renderer's colour is meaningless outside the visible area and may
  // even be X; a ternary on a known select forces a clean zero there so
  // nothing undefined can reach the pins.
  assign rgb_masked = s1_act ? bus.pix_rgb : 6'd0;

  // ---------------------------------------------------------------------
  // Stage 2: output byte in TinyVGA PMOD order
  // pix_rgb = {R1,R0,G1,G0,B1,B0}
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.vga_out <= {SYNC_IDLE, 3'b000, SYNC_IDLE, 3'b000};
    end else if (bus.pix_en) begin
      bus.vga_out <= {s1_hs, rgb_masked[0], rgb_masked[2], rgb_masked[4],
                      s1_vs, rgb_masked[1], rgb_masked[3], rgb_masked[5]};
    end
  end

endmodule

// File: tb/tb_gpu_vga_timing.sv
// tb_gpu_vga_timing: bench for gpu_vga_timing.
// Two instances share clock, reset, enable and colour: one with the default
// 640x480 timing (horizontal detail) and one with a small raster so that
// whole frames, vsync and the frame wrap fit in a short run.
module tb_gpu_vga_timing;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en = 1'b0;
  logic [5:0] pix_rgb = 6'd0;

  always #5 clk = ~clk;

  gpu_vga_timing_if bus_d ();
  gpu_vga_timing_if bus_s ();

  assign bus_d.pix_en  = pix_en;
  assign bus_d.pix_rgb = pix_rgb;
  assign bus_s.pix_en  = pix_en;
  assign bus_s.pix_rgb = pix_rgb;

  gpu_vga_timing u_dut_d (
    .clk (clk),
    .rst (rst),
    .bus (bus_d)
  );

  gpu_vga_timing #(
    .H_ACTIVE (16), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_ACTIVE (12), .V_FP (2), .V_SYNC (2), .V_BP (3),
    .SYNC_ACTIVE (1'b0)
  ) u_dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  // ---------------------------------------------------------------------
  // Reference model: raster geometry per configuration (0 default, 1 small)
  // ---------------------------------------------------------------------
  int ha [2] = '{640, 16};
  int hf [2] = '{16, 4};
  int hw [2] = '{96, 8};
  int hb [2] = '{48, 4};
  int va [2] = '{480, 12};
  int vf [2] = '{10, 2};
  int vw [2] = '{2, 2};
  int vb [2] = '{33, 3};

  int         n;           // enabled edges since reset release
  logic [5:0] rgb_hist[$]; // colour driven before enabled edge j is entry j-1

  int total = 0;
  int bad   = 0;

  function automatic int h_total(input int c);
    return ha[c] + hf[c] + hw[c] + hb[c];
  endfunction

  function automatic int v_total(input int c);
    return va[c] + vf[c] + vw[c] + vb[c];
  endfunction

  // Beam position after m enabled edges: plain raster arithmetic.
  function automatic void beam(input int c, input int m, output int px, output int py);
    int p;
    p  = m % (h_total(c) * v_total(c));
    px = p % h_total(c);
    py = p / h_total(c);
  endfunction

  function automatic logic [7:0] exp_vga(input int c, input int k);
    int px, py;
    logic hs_l, vs_l, vis;
    logic [1:0] r, g, b;
    logic [5:0] col;
    if (k < 2) return 8'h88;
    beam(c, k - 2, px, py);
    hs_l = (px >= ha[c] + hf[c] && px < ha[c] + hf[c] + hw[c]) ? 1'b0 : 1'b1;
    vs_l = (py >= va[c] + vf[c] && py < va[c] + vf[c] + vw[c]) ? 1'b0 : 1'b1;
    vis  = (px < ha[c]) && (py < va[c]);
    col  = vis ? rgb_hist[k - 1] : 6'd0;
    r = col[5:4];
    g = col[3:2];
    b = col[1:0];
    return {hs_l, b[0], g[0], r[0], vs_l, b[1], g[1], r[1]};
  endfunction

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_all();
    int px, py;
    beam(0, n, px, py);
    chk("d_x", 32'(bus_d.x), 32'(px));
    chk("d_y", 32'(bus_d.y), 32'(py));
    chk("d_active", 32'(bus_d.active), 32'((px < ha[0]) && (py < va[0])));
    chk("d_line_start", 32'(bus_d.line_start), 32'(px == 0));
    chk("d_frame_start", 32'(bus_d.frame_start), 32'(px == 0 && py == 0));
    chk("d_vblank", 32'(bus_d.vblank), 32'(py >= va[0]));
    chk("d_vga", 32'(bus_d.vga_out), 32'(exp_vga(0, n)));
    beam(1, n, px, py);
    chk("s_x", 32'(bus_s.x), 32'(px));
    chk("s_y", 32'(bus_s.y), 32'(py));
    chk("s_active", 32'(bus_s.active), 32'((px < ha[1]) && (py < va[1])));
    chk("s_line_start", 32'(bus_s.line_start), 32'(px == 0));
    chk("s_frame_start", 32'(bus_s.frame_start), 32'(px == 0 && py == 0));
    chk("s_vblank", 32'(bus_s.vblank), 32'(py >= va[1]));
    chk("s_vga", 32'(bus_s.vga_out), 32'(exp_vga(1, n)));
  endtask

  // ---------------------------------------------------------------------
  // Driver: one clock with the given enable and a random colour; the bench
  // is just past a negedge on entry and on return.
  // ---------------------------------------------------------------------
  task automatic tick(input logic en);
    pix_en  = en;
    pix_rgb = 6'($urandom_range(0, 63));
    if (en) rgb_hist.push_back(pix_rgb);
    @(posedge clk);
    if (en) n++;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_d_x"}, 32'(bus_d.x), 32'd0);
    chk({tag, "_d_y"}, 32'(bus_d.y), 32'd0);
    chk({tag, "_d_vga"}, 32'(bus_d.vga_out), 32'h88);
    chk({tag, "_d_frame_start"}, 32'(bus_d.frame_start), 32'd1);
    chk({tag, "_d_line_start"}, 32'(bus_d.line_start), 32'd1);
    chk({tag, "_d_active"}, 32'(bus_d.active), 32'd1);
    chk({tag, "_d_vblank"}, 32'(bus_d.vblank), 32'd0);
    chk({tag, "_s_x"}, 32'(bus_s.x), 32'd0);
    chk({tag, "_s_y"}, 32'(bus_s.y), 32'd0);
    chk({tag, "_s_vga"}, 32'(bus_s.vga_out), 32'h88);
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    int first_hs, hs_len, act_cnt, ls_cnt, fs_cnt, vs_len;
    int px, py, guard;
    bit reached;

    n = 0;
    // Power-on reset.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("por");

    // Release, run mid-line, then reset while running.
    rst = 1'b0;
    repeat (300) tick(1'b1);
    check_all();
    #2 rst = 1'b1;
    #1 check_reset_values("async_rst");
    @(negedge clk);
    check_reset_values("rst_held");
    rst = 1'b0;
    n = 0;
    rgb_hist.delete();

    // Free-running: horizontal detail on the default raster, full frames on
    // the small one.
    first_hs = -1;
    hs_len = 0; act_cnt = 0; ls_cnt = 0; fs_cnt = 0; vs_len = 0;
    for (int i = 0; i < 2000; i++) begin
      tick(1'b1);
      check_all();
      if (n <= 800) begin
        if (bus_d.vga_out[7] == 1'b0) begin
          if (first_hs < 0) first_hs = n;
          hs_len++;
        end
        if (bus_d.active) act_cnt++;
      end
      if (n <= 608 && bus_s.vga_out[3] == 1'b0) vs_len++;
      if (bus_d.line_start) ls_cnt++;
      if (bus_s.frame_start) fs_cnt++;
    end
    chk("hsync_first_edge", 32'(first_hs), 32'd658);
    chk("hsync_width", 32'(hs_len), 32'd96);
    chk("active_per_line", 32'(act_cnt), 32'd640);
    chk("line_start_count", 32'(ls_cnt), 32'd2);
    chk("s_vsync_width", 32'(vs_len), 32'd64);
    chk("s_frame_start_count", 32'(fs_cnt), 32'd3);

    // Stalled run: the model only advances on enabled edges.
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 3) != 0);
      check_all();
    end

    // Walk until the small raster's output byte shows both syncs asserted,
    // then reset in the middle of that pulse.
    reached = 1'b0;
    guard = 0;
    while (!reached && guard < 1000) begin
      tick(1'b1);
      check_all();
      if (n >= 2) begin
        beam(1, n - 2, px, py);
        reached = (px == 22) && (py == 15);
      end
      guard++;
    end
    chk("rst_point_reached", 32'(reached), 32'd1);
    chk("s_sync_low_before_rst", 32'(bus_s.vga_out[7] | bus_s.vga_out[3]), 32'd0);
    #2 rst = 1'b1;
    #1 check_reset_values("midframe_rst");
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    rgb_hist.delete();

    // Restart from (0,0) with a stalled enable.
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 4) != 0);
      check_all();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpu_vga_timing.md
# gpu_vga_timing

VGA raster timing stage for the GPU tile. It generates the 640x480@60 horizontal and vertical counters, and gives the pixel renderer the current beam coordinates. It then pipelines sync and blanking to match the renderer's one-cycle colour latency. Its output is the final registered byte in TinyVGA PMOD order, driven straight onto `uo_out` by `tt_um_emern_top`.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch, in clocks
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch, in lines
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `SYNC_ACTIVE`, 0, sync pulse level (0 = active-low)

Ports:
- `clk`  in  1  pixel clock, 25.175 MHz nominal
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `pix_en`  in  1  advance enable; when low, the whole block holds state
- `x`  out  10  current horizontal count, 0..H_TOTAL-1
- `y`  out  10  current vertical count, 0..V_TOTAL-1
- `active`  out  1  x < H_ACTIVE and y < V_ACTIVE
- `line_start`  out  1  x == 0
- `frame_start`  out  1  x == 0 and y == 0
- `vblank`  out  1  y >= V_ACTIVE
- `pix_rgb`  in  6  renderer colour {R[1:0],G[1:0],B[1:0]} for the coordinates presented one enabled cycle earlier
- `vga_out`  out  8  {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}

## Operation
- Derived totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Counters `hc` and `vc` are 10-bit registers. `x`, `y`, `active`, `line_start`, `frame_start` and `vblank` are pure decodes of these registers; no extra delay.
- On each clock with `pix_en`=1:
  - `hc` increments.
  - At `hc` == H_TOTAL-1, `hc` wraps to 0 and `vc` increments.
  - At `hc` == H_TOTAL-1 and `vc` == V_TOTAL-1, both wrap to 0.
- Raw sync windows:
  - hsync is asserted for `hc` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
  - vsync is asserted for `vc` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491.
  - Asserted means level SYNC_ACTIVE; otherwise the level is ~SYNC_ACTIVE.
- Stage 1 register: on each `pix_en`, captures raw hsync, vsync and `active` of the current counters.
- Stage 2 register (`vga_out`): on each `pix_en`, captures the stage 1 sync bits plus `pix_rgb`. `pix_rgb` is forced to 0 when stage 1 `active` is 0.
- `pix_rgb` is don't-care during blanking. X or garbage there must never reach `vga_out`.
- `pix_en`=0 freezes counters, stage 1 and `vga_out`; decoded outputs stay stable.

## Timing
- Reset (asynchronous assert, synchronous to `clk` on release):
  - `hc`=0, `vc`=0, so `x`=0, `y`=0, `active`=1, `line_start`=1, `frame_start`=1, `vblank`=0.
  - Stage 1 holds sync inactive and active=0.
  - `vga_out` = {~SYNC_ACTIVE,000,~SYNC_ACTIVE,000}, which is 8'h88 for default polarity.
- Latency: the state of counter (x,y) at enabled cycle N appears on `vga_out` after enabled cycle N+2. The renderer must present colour for (x,y) during enabled cycle N+1.
- The first hsync assertion on `vga_out` is visible after the 658th enabled edge following reset release (hc=656 plus 2 pipeline stages).
- Frame period is exactly 420000 enabled clocks. `frame_start` is high for exactly 1 enabled cycle per frame.
- Reset mid-frame:
  - Counters and both pipeline stages clear immediately.
  - No partial sync pulse may persist past reset assertion.
  - The next frame begins at (0,0) on the first enabled edge after release.
- `pix_en` toggling: results must be identical to an unstalled run with the disabled cycles removed.

## Test plan
- Reset: hold `rst`=1 mid-line -> `x`=0, `y`=0, `vga_out`=8'h88, `frame_start`=1 while reset is held.
- Horizontal timing, `pix_en`=1 -> `vga_out[7]` low for exactly 96 clocks, starting 658 clocks after release; `line_start` period is 800 clocks; `active` is high for 640 clocks per line in lines 0..479.
- Vertical timing and wrap -> `vga_out[3]` low for exactly 1600 clocks (lines 490..491); `frame_start` recurs after 420000 clocks; `y` goes 524 -> 0 on the same edge that `x` goes 799 -> 0.
- Blanking mask: drive `pix_rgb`=6'h3F constantly -> `vga_out` colour bits are all ones only for the 2-cycle-delayed active region; they are 0 at x=640..799 delayed and in lines 480..524.
- Colour alignment: drive `pix_rgb` = low 6 bits of (x-1) -> the byte in `vga_out` at delayed position x equals low bits of x, with no off-by-one.
- Stall: toggle `pix_en` pseudo-randomly -> the sequence of `vga_out` samples taken on enabled cycles matches the reference unstalled run exactly. Also assert `rst` for 1 cycle at (x=700, y=491) -> sync bits return to 1 immediately and the counters restart at (0,0).
